// File: rtl/cpu_sram_arbiter_pkg.sv
// Shared encodings for the two-requester SRAM-like arbiter: owner bits,
// grant FSM states and SRAM-like size codes.
package cpu_sram_arbiter_pkg;

  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_HOLD_INST = 2'd1,
    ST_HOLD_DATA = 2'd2
  } grant_state_e;

  // bytes = 1 << size
  localparam logic [1:0] SIZE_1B = 2'd0;
  localparam logic [1:0] SIZE_2B = 2'd1;
  localparam logic [1:0] SIZE_4B = 2'd2;

  function automatic grant_state_e hold_state(input logic owner);
    return owner ? ST_HOLD_DATA : ST_HOLD_INST;
  endfunction

endpackage

// File: rtl/cpu_sram_arbiter_if.sv
// One SRAM-like channel. master issues requests, slave answers them.
interface cpu_sram_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req;
  logic          wr;
  logic [1:0]    size;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          addr_ok;
  logic [DW-1:0] rdata;
  logic          data_ok;

  modport master (output req, wr, size, addr, wdata,
                  input  addr_ok, rdata, data_ok);
  modport slave  (input  req, wr, size, addr, wdata,
                  output addr_ok, rdata, data_ok);
endinterface

// File: rtl/sram_arb_owner_fifo.sv
// In-order owner queue: one bit per accepted transaction, popped on each
// downstream response. Pointers wrap modulo DEPTH.
module sram_arb_owner_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/cpu_sram_arbiter.sv
// Shares one SRAM-like port between inst fetch and load/store. Optional
// SRAM_ARB_ROUND_ROBIN_EN swaps fixed data priority for round-robin.
module cpu_sram_arbiter
  import cpu_sram_arbiter_pkg::*;
#(
  parameter int AW              = 32,
  parameter int DW              = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  cpu_sram_arbiter_if.slave    inst_bus,
  cpu_sram_arbiter_if.slave    data_bus,
  cpu_sram_arbiter_if.master   m_bus
);
  grant_state_e  state_q, state_d;
  logic          winner, grant_owner, gnt_req, accept, pop;
  logic          full, empty, head;
  logic [AW-1:0] gnt_addr;
  logic [DW-1:0] gnt_wdata;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic last_grant_q, last_grant_d;

  // Under contention the requester that did not win last time goes first.
  always_comb begin
    winner = OWNER_INST;
    if (data_bus.req && (!inst_bus.req || last_grant_q == OWNER_INST))
      winner = OWNER_DATA;
    last_grant_d = accept ? grant_owner : last_grant_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) last_grant_q <= OWNER_INST;
    else         last_grant_q <= last_grant_d;
  end
`else
  always_comb begin
    winner = data_bus.req ? OWNER_DATA : OWNER_INST;
  end
`endif

  always_comb begin
    grant_owner = winner;
    case (state_q)
      ST_HOLD_INST: grant_owner = OWNER_INST;
      ST_HOLD_DATA: grant_owner = OWNER_DATA;
      default:      grant_owner = winner;
    endcase
  end

  assign gnt_req   = grant_owner ? data_bus.req   : inst_bus.req;
  assign gnt_addr  = grant_owner ? data_bus.addr  : inst_bus.addr;
  assign gnt_wdata = grant_owner ? data_bus.wdata : inst_bus.wdata;

  assign m_bus.req   = resetn && gnt_req && !full;
  assign m_bus.wr    = grant_owner ? data_bus.wr   : inst_bus.wr;
  assign m_bus.size  = grant_owner ? data_bus.size : inst_bus.size;
  assign m_bus.addr  = gnt_addr;
  assign m_bus.wdata = gnt_wdata;

  assign accept = m_bus.req && m_bus.addr_ok;
  assign inst_bus.addr_ok = accept && (grant_owner == OWNER_INST);
  assign data_bus.addr_ok = accept && (grant_owner == OWNER_DATA);

  // Responses with nothing outstanding are dropped here.
  assign pop = resetn && m_bus.data_ok && !empty;
  assign inst_bus.data_ok = pop && (head == OWNER_INST);
  assign data_bus.data_ok = pop && (head == OWNER_DATA);
  assign inst_bus.rdata   = m_bus.rdata;
  assign data_bus.rdata   = m_bus.rdata;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (m_bus.req && !m_bus.addr_ok) state_d = hold_state(grant_owner);
      ST_HOLD_INST,
      ST_HOLD_DATA: if (accept) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  sram_arb_owner_fifo #(.DEPTH(MAX_OUTSTANDING)) u_owner_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (accept),
    .din    (grant_owner),
    .pop    (pop),
    .full   (full),
    .empty  (empty),
    .head   (head)
  );

endmodule

// File: tb/tb_cpu_sram_arbiter.sv
// Scenario bench for cpu_sram_arbiter; owner scoreboard filled on accept,
// drained on each downstream response.
module tb_cpu_sram_arbiter;
  import cpu_sram_arbiter_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  cpu_sram_arbiter_if #(.AW(32), .DW(32)) inst_if ();
  cpu_sram_arbiter_if #(.AW(32), .DW(32)) data_if ();
  cpu_sram_arbiter_if #(.AW(32), .DW(32)) m_if ();

  cpu_sram_arbiter #(.AW(32), .DW(32), .MAX_OUTSTANDING(2)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .inst_bus (inst_if),
    .data_bus (data_if),
    .m_bus    (m_if)
  );

  int   checks = 0;
  int   errors = 0;
  logic exp_owner[$];

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs;
    inst_if.req = 0; inst_if.wr = 0; inst_if.size = SIZE_4B; inst_if.addr = '0; inst_if.wdata = '0;
    data_if.req = 0; data_if.wr = 0; data_if.size = SIZE_4B; data_if.addr = '0; data_if.wdata = '0;
    m_if.addr_ok = 0; m_if.rdata = '0; m_if.data_ok = 0;
  endtask

  // Drive one downstream response and compare routing against the scoreboard.
  task automatic respond(input logic [31:0] rd);
    logic have, own;
    have = (exp_owner.size() != 0);
    own  = have ? exp_owner.pop_front() : OWNER_INST;
    m_if.data_ok = 1; m_if.rdata = rd;
    #1;
    checks++;
    if (inst_if.data_ok !== (have && own == OWNER_INST)) begin
      errors++; $display("FAIL resp_inst_data_ok got %b exp %b", inst_if.data_ok, have && own == OWNER_INST);
    end
    checks++;
    if (data_if.data_ok !== (have && own == OWNER_DATA)) begin
      errors++; $display("FAIL resp_data_data_ok got %b exp %b", data_if.data_ok, have && own == OWNER_DATA);
    end
    if (have) begin
      checks++;
      if ((own ? data_if.rdata : inst_if.rdata) !== rd) begin
        errors++; $display("FAIL resp_rdata got %h exp %h", own ? data_if.rdata : inst_if.rdata, rd);
      end
    end
    tick;
    m_if.data_ok = 0;
  endtask

  task automatic test_reset;
    resetn = 0;
    inst_if.req = 1; inst_if.addr = 32'hbfc00000;
    m_if.addr_ok = 1; m_if.data_ok = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (m_if.req !== 1'b0 || inst_if.addr_ok !== 1'b0 || inst_if.data_ok !== 1'b0) begin
        errors++; $display("FAIL reset_outputs got req=%b aok=%b dok=%b exp 0", m_if.req, inst_if.addr_ok, inst_if.data_ok);
      end
      tick;
    end
    resetn = 1; m_if.addr_ok = 0; m_if.data_ok = 0;
    #1;
    checks++;
    if (m_if.req !== 1'b1 || m_if.addr !== 32'hbfc00000) begin
      errors++; $display("FAIL reset_release got req=%b addr=%h exp 1 bfc00000", m_if.req, m_if.addr);
    end
    tick;
    respond(32'hdead_0000);             // late response after reset: queue empty
    m_if.addr_ok = 1;
    #1;
    checks++;
    if (inst_if.addr_ok !== 1'b1) begin
      errors++; $display("FAIL reset_first_accept got %b exp 1", inst_if.addr_ok);
    end
    exp_owner.push_back(OWNER_INST);
    tick;
    inst_if.req = 0; m_if.addr_ok = 0;
    respond(32'h0000_0001);
  endtask

  task automatic test_contention;
    logic second;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    second = OWNER_INST;
`else
    second = OWNER_DATA;
`endif
    inst_if.req = 1; inst_if.addr = 32'h0000_1000;
    data_if.req = 1; data_if.addr = 32'h0000_2000; data_if.wr = 1; data_if.wdata = 32'hcafe_f00d;
    m_if.addr_ok = 1;
    #1;
    checks++;
    if (m_if.addr !== 32'h0000_2000 || m_if.wr !== 1'b1 || m_if.wdata !== 32'hcafe_f00d) begin
      errors++; $display("FAIL contend_first_mux got addr=%h wr=%b wdata=%h exp 00002000 1 cafef00d", m_if.addr, m_if.wr, m_if.wdata);
    end
    checks++;
    if (data_if.addr_ok !== 1'b1 || inst_if.addr_ok !== 1'b0) begin
      errors++; $display("FAIL contend_first_aok got d=%b i=%b exp 1 0", data_if.addr_ok, inst_if.addr_ok);
    end
    exp_owner.push_back(OWNER_DATA);
    tick;
    data_if.addr = 32'h0000_2004; data_if.wr = 0;
    #1;
    checks++;
    if (m_if.addr !== (second ? 32'h0000_2004 : 32'h0000_1000) ||
        inst_if.addr_ok !== (second == OWNER_INST) || data_if.addr_ok !== (second == OWNER_DATA)) begin
      errors++; $display("FAIL contend_second got addr=%h i=%b d=%b exp owner %b", m_if.addr, inst_if.addr_ok, data_if.addr_ok, second);
    end
    exp_owner.push_back(second);
    tick;
    #1;
    checks++;
    if (m_if.req !== 1'b0) begin
      errors++; $display("FAIL contend_full_req got %b exp 0", m_if.req);
    end
    inst_if.req = 0; data_if.req = 0; m_if.addr_ok = 0;
    respond(32'haaaa_0001);
    respond(32'haaaa_0002);
  endtask

  task automatic test_hold;
    inst_if.req = 1; inst_if.addr = 32'h0000_3000; m_if.addr_ok = 0;
    tick;
    data_if.req = 1; data_if.addr = 32'h0000_4000;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (m_if.addr !== 32'h0000_3000 || data_if.addr_ok !== 1'b0 || inst_if.addr_ok !== 1'b0) begin
        errors++; $display("FAIL hold_locked got addr=%h d=%b i=%b exp 00003000 0 0", m_if.addr, data_if.addr_ok, inst_if.addr_ok);
      end
      tick;
    end
    m_if.addr_ok = 1;
    #1;
    checks++;
    if (inst_if.addr_ok !== 1'b1 || data_if.addr_ok !== 1'b0) begin
      errors++; $display("FAIL hold_release got i=%b d=%b exp 1 0", inst_if.addr_ok, data_if.addr_ok);
    end
    exp_owner.push_back(OWNER_INST);
    tick;
    inst_if.req = 0;
    #1;
    checks++;
    if (m_if.addr !== 32'h0000_4000 || data_if.addr_ok !== 1'b1) begin
      errors++; $display("FAIL hold_idle_next got addr=%h d=%b exp 00004000 1", m_if.addr, data_if.addr_ok);
    end
    exp_owner.push_back(OWNER_DATA);
    tick;
    data_if.req = 0; m_if.addr_ok = 0;
    respond(32'hbbbb_0001);
    respond(32'hbbbb_0002);
  endtask

  task automatic test_full;
    logic own;
    inst_if.req = 1; m_if.addr_ok = 1;
    for (int k = 0; k < 2; k++) begin
      inst_if.addr = 32'h0000_5000 + 32'(k * 4);
      #1;
      checks++;
      if (inst_if.addr_ok !== 1'b1) begin
        errors++; $display("FAIL full_fill%0d got %b exp 1", k, inst_if.addr_ok);
      end
      exp_owner.push_back(OWNER_INST);
      tick;
    end
    inst_if.addr = 32'h0000_5008;
    #1;
    checks++;
    if (m_if.req !== 1'b0 || inst_if.addr_ok !== 1'b0) begin
      errors++; $display("FAIL full_blocked got req=%b aok=%b exp 0 0", m_if.req, inst_if.addr_ok);
    end
    own = exp_owner.pop_front();
    m_if.data_ok = 1; m_if.rdata = 32'hcccc_0001;
    #1;
    checks++;
    if (inst_if.data_ok !== (own == OWNER_INST) || inst_if.rdata !== 32'hcccc_0001 || inst_if.addr_ok !== 1'b0) begin
      errors++; $display("FAIL full_pop got dok=%b rdata=%h aok=%b exp 1 cccc0001 0", inst_if.data_ok, inst_if.rdata, inst_if.addr_ok);
    end
    tick;
    m_if.data_ok = 0;
    #1;
    checks++;
    if (inst_if.addr_ok !== 1'b1 || m_if.addr !== 32'h0000_5008) begin
      errors++; $display("FAIL full_third_accept got aok=%b addr=%h exp 1 00005008", inst_if.addr_ok, m_if.addr);
    end
    exp_owner.push_back(OWNER_INST);
    tick;
    inst_if.req = 0; m_if.addr_ok = 0;
    respond(32'hcccc_0002);
    respond(32'hcccc_0003);
  endtask

  task automatic test_ordering;
    logic own;
    inst_if.req = 1; inst_if.addr = 32'h0000_6000; m_if.addr_ok = 1;
    #1;
    exp_owner.push_back(OWNER_INST);
    tick;
    inst_if.req = 0;
    data_if.req = 1; data_if.addr = 32'h0000_7000;
    own = exp_owner.pop_front();
    m_if.data_ok = 1; m_if.rdata = 32'h1111_1111;
    #1;
    checks++;
    if (data_if.addr_ok !== 1'b1 || inst_if.data_ok !== (own == OWNER_INST) ||
        data_if.data_ok !== 1'b0 || inst_if.rdata !== 32'h1111_1111) begin
      errors++; $display("FAIL order_push_pop got daok=%b idok=%b ddok=%b rdata=%h exp 1 1 0 11111111",
                         data_if.addr_ok, inst_if.data_ok, data_if.data_ok, inst_if.rdata);
    end
    exp_owner.push_back(OWNER_DATA);
    tick;
    data_if.req = 0; m_if.addr_ok = 0; m_if.data_ok = 0;
    respond(32'h2222_2222);
    respond(32'h3333_3333);             // nothing outstanding
  endtask

  task automatic test_spurious;
    respond(32'hbad0_bad0);
    data_if.req = 1; data_if.addr = 32'h0000_8000; m_if.addr_ok = 1;
    #1;
    checks++;
    if (data_if.addr_ok !== 1'b1 || m_if.addr !== 32'h0000_8000) begin
      errors++; $display("FAIL spurious_accept got aok=%b addr=%h exp 1 00008000", data_if.addr_ok, m_if.addr);
    end
    exp_owner.push_back(OWNER_DATA);
    tick;
    data_if.req = 0; m_if.addr_ok = 0;
    respond(32'h4444_4444);
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_contention();
    test_hold();
    test_full();
    test_ordering();
    test_spurious();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
